btn_debounce_pulse: RTL and testbench

//   Front-end conditioner for the TV-remote channel buttons (up/down). Synchronises raw

---
 rtl/btn_debounce_pulse.sv | 134 +++++++++++++
 tb/tb_btn_debounce_pulse.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_pulse.sv
// Channel-button front end: 2-FF synchroniser, per-button debounce filter and a
// press/hold-to-repeat pulse generator. Each button is handled independently.
module btn_debounce_pulse #(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 50000,
  parameter int unsigned REPEAT_PERIOD   = 20000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HW   = $clog2(HMax + 1);

  localparam logic [DW-1:0] DebLast    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] DelayLast  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PeriodLast = HW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    StReleased,
    StFirstHold,
    StRepeat
  } state_e;

  logic [N_BTN-1:0] sync_meta_q;
  logic [N_BTN-1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= btn_in;
      sync_q      <= sync_meta_q;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          level_q, level_d;
    logic          rise, fall;
    state_e        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          pulse_q, pulse_d;

    // Any cycle where the synchronised input agrees with the accepted level restarts the count.
    always_comb begin
      dcnt_d  = '0;
      level_d = level_q;
      rise    = 1'b0;
      fall    = 1'b0;
      if (sync_q[i] != level_q) begin
        if (dcnt_q == DebLast) begin
          level_d = sync_q[i];
          rise    = sync_q[i];
          fall    = ~sync_q[i];
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
    end

    // The press pulse is decided from the acceptance itself so it lands with the level edge.
    // Release wins over a repeat that would fall due on the same cycle.
    always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      pulse_d = 1'b0;
      if (fall) begin
        state_d = StReleased;
        hcnt_d  = '0;
      end else begin
        case (state_q)
          StReleased: begin
            if (rise) begin
              pulse_d = 1'b1;
              hcnt_d  = '0;
              state_d = StFirstHold;
            end
          end
          StFirstHold: begin
            if (REPEAT_EN) begin
              if (hcnt_q == DelayLast) begin
                pulse_d = 1'b1;
                hcnt_d  = '0;
                state_d = StRepeat;
              end else begin
                hcnt_d = hcnt_q + 1'b1;
              end
            end
          end
          StRepeat: begin
            if (hcnt_q == PeriodLast) begin
              pulse_d = 1'b1;
              hcnt_d  = '0;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
          default: begin
            state_d = StReleased;
            hcnt_d  = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        dcnt_q  <= '0;
        level_q <= 1'b0;
        state_q <= StReleased;
        hcnt_q  <= '0;
        pulse_q <= 1'b0;
      end else begin
        dcnt_q  <= dcnt_d;
        level_q <= level_d;
        state_q <= state_d;
        hcnt_q  <= hcnt_d;
        pulse_q <= pulse_d;
      end
    end

    assign btn_level[i] = level_q;
    assign btn_pulse[i] = pulse_q;
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench: stimulus queues expected pulses (cycle + vector), a negedge monitor
// pops and compares every non-zero btn_pulse; levels are checked inline.
module tb_btn_debounce_pulse;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] btn_a, btn_bc;
  logic [1:0] level_a, pulse_a, level_b, pulse_b, level_c, pulse_c;

  always #5 clk = ~clk;

  // dut_a: defaults; dut_b: fast repeat; dut_c: fast, repeat disabled.
  btn_debounce_pulse #(
    .N_BTN(2), .DEBOUNCE_CYCLES(1000), .REPEAT_EN(1'b1),
    .REPEAT_DELAY(50000), .REPEAT_PERIOD(20000)
  ) dut_a (
    .clk(clk), .rstn(rstn), .btn_in(btn_a), .btn_level(level_a), .btn_pulse(pulse_a)
  );

  btn_debounce_pulse #(
    .N_BTN(2), .DEBOUNCE_CYCLES(10), .REPEAT_EN(1'b1), .REPEAT_DELAY(100), .REPEAT_PERIOD(20)
  ) dut_b (
    .clk(clk), .rstn(rstn), .btn_in(btn_bc), .btn_level(level_b), .btn_pulse(pulse_b)
  );

  btn_debounce_pulse #(
    .N_BTN(2), .DEBOUNCE_CYCLES(10), .REPEAT_EN(1'b0), .REPEAT_DELAY(100), .REPEAT_PERIOD(20)
  ) dut_c (
    .clk(clk), .rstn(rstn), .btn_in(btn_bc), .btn_level(level_c), .btn_pulse(pulse_c)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic [1:0] vec;
  } exp_t;

  exp_t q_a[$], q_b[$], q_c[$];
  exp_t e_a, e_b, e_c, e_new;
  int   t, u, r;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: cyc=%0d got %b required %b", name, cyc, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic push(input int which, input int c, input logic [1:0] v);
    e_new.cyc = c;
    e_new.vec = v;
    case (which)
      0:       q_a.push_back(e_new);
      1:       q_b.push_back(e_new);
      default: q_c.push_back(e_new);
    endcase
  endtask

  // Drive point: just after the edge that makes cyc == c.
  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (pulse_a !== 2'b00) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL pulse_a: got %b at cyc=%0d, required no pulse", pulse_a, cyc);
      end else begin
        e_a = q_a.pop_front();
        if (e_a.cyc != cyc || e_a.vec !== pulse_a) begin
          errors++;
          $display("FAIL pulse_a: got %b at cyc=%0d, required %b at cyc=%0d",
                   pulse_a, cyc, e_a.vec, e_a.cyc);
        end
      end
    end
    if (pulse_b !== 2'b00) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL pulse_b: got %b at cyc=%0d, required no pulse", pulse_b, cyc);
      end else begin
        e_b = q_b.pop_front();
        if (e_b.cyc != cyc || e_b.vec !== pulse_b) begin
          errors++;
          $display("FAIL pulse_b: got %b at cyc=%0d, required %b at cyc=%0d",
                   pulse_b, cyc, e_b.vec, e_b.cyc);
        end
      end
    end
    if (pulse_c !== 2'b00) begin
      checks++;
      if (q_c.size() == 0) begin
        errors++;
        $display("FAIL pulse_c: got %b at cyc=%0d, required no pulse", pulse_c, cyc);
      end else begin
        e_c = q_c.pop_front();
        if (e_c.cyc != cyc || e_c.vec !== pulse_c) begin
          errors++;
          $display("FAIL pulse_c: got %b at cyc=%0d, required %b at cyc=%0d",
                   pulse_c, cyc, e_c.vec, e_c.cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: cyc=%0d required completion", cyc);
    $fatal(1);
  end

  initial begin
    // T1: reset held with both buttons pressed
    rstn   = 1'b0;
    btn_a  = 2'b11;
    btn_bc = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t1_level_a", level_a, 2'b00);
      check("t1_level_b", level_b, 2'b00);
      check("t1_level_c", level_c, 2'b00);
    end
    btn_a  = 2'b00;
    btn_bc = 2'b00;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    go(cyc + 5);

    // T2: clean 100 us press on dut_a
    t = cyc;
    btn_a = 2'b01;
    push(0, t + 1002, 2'b01);
    at(t + 1001);
    check("t2_level_before", level_a, 2'b00);
    at(t + 1002);
    check("t2_level_rise", level_a, 2'b01);
    go(t + 10000);
    btn_a = 2'b00;
    r = cyc;
    at(r + 1001);
    check("t2_level_hold", level_a, 2'b01);
    at(r + 1002);
    check("t2_level_fall", level_a, 2'b00);
    go(r + 1100);

    // T3: 999-cycle glitch, then bouncing press
    t = cyc;
    btn_a = 2'b01;
    go(t + 999);
    btn_a = 2'b00;
    at(t + 1010);
    check("t3_glitch", level_a, 2'b00);
    go(t + 1100);
    u = cyc;
    for (int i = 0; i <= 10; i++) begin
      go(u + 50 * i);
      btn_a = (i % 2 == 0) ? 2'b01 : 2'b00;
    end
    push(0, u + 1502, 2'b01);
    at(u + 1501);
    check("t3_level_before", level_a, 2'b00);
    at(u + 1502);
    check("t3_level_rise", level_a, 2'b01);
    go(u + 1600);
    btn_a = 2'b00;
    r = cyc;
    at(r + 1002);
    check("t3_level_fall", level_a, 2'b00);
    go(r + 1010);

    // T4: hold btn[1] 200 cycles on fast instances
    t = cyc;
    btn_bc = 2'b10;
    push(1, t + 12, 2'b10);
    push(1, t + 112, 2'b10);
    push(1, t + 132, 2'b10);
    push(1, t + 152, 2'b10);
    push(1, t + 172, 2'b10);
    push(1, t + 192, 2'b10);
    push(2, t + 12, 2'b10);
    at(t + 11);
    check("t4_level_before", level_b, 2'b00);
    at(t + 12);
    check("t4_level_b", level_b, 2'b10);
    check("t4_level_c", level_c, 2'b10);
    go(t + 200);
    btn_bc = 2'b00;
    r = cyc;
    at(r + 12);
    check("t4_level_fall", level_b, 2'b00);
    go(r + 40);

    // T5: simultaneous, then staggered by 5 cycles
    t = cyc;
    btn_bc = 2'b11;
    push(1, t + 12, 2'b11);
    push(2, t + 12, 2'b11);
    at(t + 12);
    check("t5_level_both", level_b, 2'b11);
    go(t + 50);
    btn_bc = 2'b00;
    go(t + 90);
    t = cyc;
    btn_bc = 2'b01;
    push(1, t + 12, 2'b01);
    push(2, t + 12, 2'b01);
    push(1, t + 17, 2'b10);
    push(2, t + 17, 2'b10);
    go(t + 5);
    btn_bc = 2'b11;
    at(t + 13);
    check("t5_stagger_level", level_c, 2'b01);
    go(t + 50);
    btn_bc = 2'b00;
    go(t + 90);

    // T6: reset while dut_b is repeating with the button held
    t = cyc;
    btn_bc = 2'b01;
    push(1, t + 12, 2'b01);
    push(1, t + 112, 2'b01);
    push(1, t + 132, 2'b01);
    push(2, t + 12, 2'b01);
    go(t + 142);
    check("t6_level_held", level_b, 2'b01);
    #1;
    rstn = 1'b0;
    #1;
    check("t6_async_level_b", level_b, 2'b00);
    check("t6_async_level_c", level_c, 2'b00);
    check("t6_async_pulse_b", pulse_b, 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_rst_level_b", level_b, 2'b00);
    end
    go(t + 152);
    rstn = 1'b1;
    r = cyc;
    push(1, r + 12, 2'b01);
    push(2, r + 12, 2'b01);
    at(r + 11);
    check("t6_level_before", level_b, 2'b00);
    at(r + 12);
    check("t6_level_rise", level_b, 2'b01);
    go(r + 50);
    btn_bc = 2'b00;
    go(r + 80);

    check_int("left_a", q_a.size(), 0);
    check_int("left_b", q_b.size(), 0);
    check_int("left_c", q_c.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
